// File: rtl/play_input_ctrl.sv
// play_input_ctrl: turns raw per-player buttons into the single-cycle
// play_valid / play_action / turn handshake consumed by the game core while
// it is in the PLAY phase. Buttons are synchronised and debounced. Only the
// active player's rising edges are accepted. An idle active player gets an
// automatic WAIT after TIMEOUT_CYCLES cycles in ARM.
module play_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 3,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int TO_W            = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       phase,
  input  logic [1:0] winner,
  input  logic [4:0] p1_btn,
  input  logic [4:0] p2_btn,
  output logic       turn,
  output logic       play_valid,
  output logic [2:0] play_action,
  output logic       timeout_flag,
  output logic       err_multi_press
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      ACT_WAIT = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [9:0]      raw, s1, s2;
  logic [9:0]      db_level, db_level_d, press;
  logic [DB_W-1:0] db_cnt [10];
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic [4:0]      active_ev;
  logic [2:0]      ev_count, ev_idx;
  logic            go;
  logic            turn_n, play_valid_n, timeout_flag_n, err_n;
  logic [2:0]      play_action_n;

  // P2 occupies the upper five bits so one event index maps to one action.
  assign raw = {p2_btn, p1_btn};

  // Two-flop synchroniser for every raw button bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Per-bit debounce: a new level is adopted after it has been seen for
  // DEBOUNCE_CYCLES consecutive samples; db_level_d feeds edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level   <= '0;
      db_level_d <= '0;
      for (int i = 0; i < 10; i++) db_cnt[i] <= '0;
    end else begin
      db_level_d <= db_level;
      for (int i = 0; i < 10; i++) begin
        if (s2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= s2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press     = db_level & ~db_level_d;
  assign active_ev = turn ? press[9:5] : press[4:0];
  assign go        = !phase && (winner == 2'b00);

  // Count the active player's press events and find the index of one of them.
  always_comb begin
    ev_count = '0;
    ev_idx   = '0;
    for (int i = 4; i >= 0; i--) begin
      if (active_ev[i]) begin
        ev_count = ev_count + 3'd1;
        ev_idx   = 3'(i);
      end
    end
  end

  // Next-state and next-output logic; a multi-press landing on the last idle
  // cycle holds the counter there so the auto-WAIT still fires next cycle.
  always_comb begin
    state_n        = state;
    to_cnt_n       = to_cnt;
    turn_n         = turn;
    play_valid_n   = 1'b0;
    play_action_n  = play_action;
    timeout_flag_n = 1'b0;
    err_n          = 1'b0;
    case (state)
      IDLE: begin
        to_cnt_n = '0;
        if (go) state_n = ARM;
      end
      ARM: begin
        if (!go) begin
          state_n  = IDLE;
          to_cnt_n = '0;
        end else if (ev_count == 3'd1) begin
          play_valid_n  = 1'b1;
          play_action_n = ev_idx;
          state_n       = ISSUE;
        end else if (ev_count >= 3'd2) begin
          err_n = 1'b1;
          if (to_cnt != TO_LAST) to_cnt_n = to_cnt + 1'b1;
        end else if (to_cnt == TO_LAST) begin
          play_valid_n   = 1'b1;
          play_action_n  = ACT_WAIT;
          timeout_flag_n = 1'b1;
          state_n        = ISSUE;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      ISSUE: begin
        turn_n   = ~turn;
        to_cnt_n = '0;
        state_n  = go ? ARM : IDLE;
      end
      default: begin
        state_n  = IDLE;
        to_cnt_n = '0;
      end
    endcase
  end

  // State, timeout counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      to_cnt          <= '0;
      turn            <= 1'b0;
      play_valid      <= 1'b0;
      play_action     <= ACT_WAIT;
      timeout_flag    <= 1'b0;
      err_multi_press <= 1'b0;
    end else begin
      state           <= state_n;
      to_cnt          <= to_cnt_n;
      turn            <= turn_n;
      play_valid      <= play_valid_n;
      play_action     <= play_action_n;
      timeout_flag    <= timeout_flag_n;
      err_multi_press <= err_n;
    end
  end

endmodule

// File: doc/play_input_ctrl.md
Name: play_input_ctrl

Overview:
Upstream stage of the game FSM. It converts raw per-player action buttons into the single-cycle play_valid / play_action / turn handshake that the game core consumes during PHASE_PLAY (phase=0). It synchronises and debounces the buttons, accepts presses only from the player whose turn it is, and alternates turns. If the active player stays idle too long, it issues an automatic WAIT.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to change a debounced level (>=1)
DB_W, 3, debounce counter width; must hold DEBOUNCE_CYCLES-1
TIMEOUT_CYCLES, 1000, idle cycles in ARM before an automatic WAIT is issued (>=2)
TO_W, 10, timeout counter width; must hold TIMEOUT_CYCLES-1

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
phase  in  1  game phase from the core: 0=PLAY, 1=SHOP
winner  in  2  winner from the core; nonzero means game over
p1_btn  in  5  raw async buttons, P1: bit0 KICK, bit1 PUNCH, bit2 LEFT, bit3 RIGHT, bit4 WAIT
p2_btn  in  5  raw async buttons, P2, same mapping
turn  out  1  active player: 0=P1, 1=P2
play_valid  out  1  one-cycle action strobe to the core
play_action  out  3  action code: KICK=0, PUNCH=1, LEFT=2, RIGHT=3, WAIT=4; valid while play_valid=1
timeout_flag  out  1  one-cycle pulse, coincident with an auto-WAIT play_valid
err_multi_press  out  1  one-cycle pulse: active player produced more than one press event in the same cycle

Behaviour:
- Reset values: turn=0, play_valid=0, play_action=3'd4, timeout_flag=0, err_multi_press=0, state=IDLE.
- Reset also clears all synchroniser flops, debounced levels, debounce counters and the timeout counter.
- Synchroniser: each of the 10 button bits passes through 2 flops (s1, s2).
- Debounce, per bit:
  - if s2 == db_level: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: db_level <= s2, cnt <= 0.
  - else: cnt <= cnt+1.
- Press event = db_level & ~db_level_d (rising edge only). A release produces no event.
- Latency: raw press stable from before edge 1 -> db_level rises at edge 2+DEBOUNCE_CYCLES -> play_valid high after edge 3+DEBOUNCE_CYCLES. For the default, that is edge 7.
- Debounce and edge detection run continuously in every state. Events that are not consumed in ARM are discarded, never queued.
- States:
  - IDLE: outputs idle. Go to ARM when phase==0 && winner==0; timeout counter <= 0.
  - ARM: consider only the events of player `turn`. The inactive player's events are dropped silently.
    - Exactly one event: register play_action = event index, play_valid=1; go to ISSUE.
    - Two or more events: err_multi_press=1 for one cycle; stay in ARM; no action issued; timeout counter keeps counting.
    - No event and timeout counter == TIMEOUT_CYCLES-1: play_action=4, play_valid=1, timeout_flag=1; go to ISSUE.
    - Otherwise: timeout counter +1.
    - Event and timeout in the same cycle: the event wins; timeout_flag stays 0.
    - phase==1 or winner!=0: go to IDLE; timeout counter <= 0; no action; turn unchanged. This check has priority over events and timeout.
  - ISSUE (exactly 1 cycle): play_valid and timeout_flag drop at the next edge. turn toggles on that same edge and is stable throughout the play_valid cycle. Timeout counter <= 0.
    - Next state is ARM if phase==0 && winner==0, else IDLE.
    - A pulse already in ISSUE always completes, even if phase or winner change during it.
- play_action holds its last value when play_valid=0.
- turn persists across SHOP phases; only rst returns it to 0.
- Asserting rst mid-ISSUE kills the pulse immediately (asynchronous clear).

Test Plan:
- Reset, then phase=0, winner=0, p1_btn=5'b00010 held -> play_valid=1 for exactly one cycle at edge 7, play_action=1; turn goes 0->1 on the following edge.
- turn=1, p1_btn KICK pressed and p2_btn RIGHT pressed together -> single play_valid with play_action=3 (the P1 press is ignored); turn returns to 0.
- P1 bit0 glitches high for 3 cycles (DEBOUNCE_CYCLES=4) -> no play_valid; bits 0 and 2 stable-pressed together -> err_multi_press pulses once, no play_valid, state stays ARM.
- TIMEOUT_CYCLES=8, no buttons pressed in ARM -> after 8 ARM cycles, play_valid=1, play_action=4, timeout_flag=1 for one cycle; turn toggles.
- In ARM, phase goes to 1 -> IDLE, no play_valid. phase returns to 0 -> timeout counter restarts from 0 and turn is unchanged. winner=2'b01 -> no further strobes.
- rst asserted during the ISSUE cycle -> play_valid=0, turn=0, play_action=4 immediately, without waiting for a clock edge.
